// File: rtl/issue_tracker_mp.sv
// In-order issue/commit tracker: multi-port dispatch, single issue, multi-port
// writeback, in-order multi-port commit, full and unissued-only flush.
module issue_tracker_mp #(
   parameter int unsigned NR_ENTRIES      = 8,
   parameter int unsigned NR_DISP_PORTS   = 2,
   parameter int unsigned NR_WB_PORTS     = 4,
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned PAYLOAD_W       = 64,
   localparam int unsigned TID_W          = $clog2(NR_ENTRIES)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 flush_i,
   input  logic                                 flush_unissued_i,
   input  logic [NR_DISP_PORTS-1:0]             disp_valid_i,
   input  logic [NR_DISP_PORTS*PAYLOAD_W-1:0]   disp_payload_i,
   output logic [NR_DISP_PORTS-1:0]             disp_ready_o,
   output logic                                 iss_valid_o,
   output logic [PAYLOAD_W-1:0]                 iss_payload_o,
   output logic [TID_W-1:0]                     iss_tid_o,
   input  logic                                 iss_ack_i,
   input  logic [NR_WB_PORTS-1:0]               wb_valid_i,
   input  logic [NR_WB_PORTS*TID_W-1:0]         wb_tid_i,
   input  logic [NR_WB_PORTS-1:0]               wb_exc_i,
   output logic [NR_COMMIT_PORTS-1:0]           commit_valid_o,
   output logic [NR_COMMIT_PORTS*PAYLOAD_W-1:0] commit_payload_o,
   output logic [NR_COMMIT_PORTS-1:0]           commit_exc_o,
   input  logic [NR_COMMIT_PORTS-1:0]           commit_ack_i,
   output logic [TID_W:0]                       count_o,
   output logic                                 full_o,
   output logic                                 empty_o
);

   localparam int unsigned PTR_W = TID_W + 1;

   typedef enum logic [1:0] {E_FREE, E_WAIT, E_ISSUED, E_DONE} entry_st_e;

   entry_st_e            st_q [NR_ENTRIES];
   entry_st_e            st_d [NR_ENTRIES];
   logic [NR_ENTRIES-1:0] exc_q, exc_d;
   logic [PAYLOAD_W-1:0] pay_q [NR_ENTRIES];

   logic [PTR_W-1:0] cmt_q, iss_q, alloc_q, cmt_d, iss_d, alloc_d;
   logic [PTR_W-1:0] count, free_cnt, n_acc, n_cmt;
   logic [TID_W-1:0] cmt_idx, iss_idx, alloc_idx;
   logic [TID_W-1:0] disp_idx [NR_DISP_PORTS];
   logic [TID_W-1:0] slot_idx [NR_COMMIT_PORTS];
   logic [NR_DISP_PORTS-1:0]   acc;
   logic [NR_COMMIT_PORTS-1:0] cmt_fire;
   logic acc_pre, cv_pre, cmt_pre, iss_fire;

   assign count     = alloc_q - cmt_q;
   assign free_cnt  = PTR_W'(NR_ENTRIES) - count;
   assign cmt_idx   = cmt_q[TID_W-1:0];
   assign iss_idx   = iss_q[TID_W-1:0];
   assign alloc_idx = alloc_q[TID_W-1:0];

   assign count_o = count;
   assign full_o  = (count == PTR_W'(NR_ENTRIES));
   assign empty_o = (count == '0);

   assign iss_valid_o   = (st_q[iss_idx] == E_WAIT);
   assign iss_payload_o = pay_q[iss_idx];
   assign iss_tid_o     = iss_idx;
   assign iss_fire      = iss_ack_i & iss_valid_o;

   always_comb begin
      for (int unsigned k = 0; k < NR_DISP_PORTS; k++)
         disp_ready_o[k] = (free_cnt > PTR_W'(k));
   end

   // Dispatch accepts only the contiguous valid&ready prefix of the ports.
   always_comb begin
      acc_pre = 1'b1;
      n_acc   = '0;
      for (int unsigned k = 0; k < NR_DISP_PORTS; k++) begin
         acc_pre     = acc_pre & disp_valid_i[k] & disp_ready_o[k];
         acc[k]      = acc_pre;
         n_acc       = n_acc + PTR_W'(acc_pre);
         disp_idx[k] = alloc_idx + TID_W'(k);
      end
   end

   always_comb begin
      cv_pre           = 1'b1;
      cmt_pre          = 1'b1;
      n_cmt            = '0;
      commit_payload_o = '0;
      for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
         slot_idx[k]       = cmt_idx + TID_W'(k);
         cv_pre            = cv_pre & (st_q[slot_idx[k]] == E_DONE);
         commit_valid_o[k] = cv_pre;
         commit_exc_o[k]   = exc_q[slot_idx[k]];
         commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = pay_q[slot_idx[k]];
         cmt_pre     = cmt_pre & commit_ack_i[k] & cv_pre;
         cmt_fire[k] = cmt_pre;
         n_cmt       = n_cmt + PTR_W'(cmt_pre);
      end
   end

   always_comb begin
      st_d    = st_q;
      exc_d   = exc_q;
      cmt_d   = cmt_q;
      iss_d   = iss_q;
      alloc_d = alloc_q;
      if (flush_i) begin
         for (int unsigned i = 0; i < NR_ENTRIES; i++)
            st_d[i] = E_FREE;
         exc_d   = '0;
         cmt_d   = '0;
         iss_d   = '0;
         alloc_d = '0;
      end else begin
         for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p] && st_q[wb_tid_i[p*TID_W +: TID_W]] == E_ISSUED) begin
               st_d[wb_tid_i[p*TID_W +: TID_W]]  = E_DONE;
               exc_d[wb_tid_i[p*TID_W +: TID_W]] = exc_d[wb_tid_i[p*TID_W +: TID_W]] | wb_exc_i[p];
            end
         end
         if (iss_fire) begin
            st_d[iss_idx] = E_ISSUED;
            iss_d         = iss_q + PTR_W'(1);
         end
         for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (cmt_fire[k]) begin
               st_d[slot_idx[k]]  = E_FREE;
               exc_d[slot_idx[k]] = 1'b0;
            end
         end
         cmt_d = cmt_q + n_cmt;
         // Partial flush is evaluated after issue so a same-cycle ack survives it.
         if (flush_unissued_i) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++)
               if (st_d[i] == E_WAIT) st_d[i] = E_FREE;
            alloc_d = iss_d;
         end else begin
            for (int unsigned k = 0; k < NR_DISP_PORTS; k++) begin
               if (acc[k]) begin
                  st_d[disp_idx[k]]  = E_WAIT;
                  exc_d[disp_idx[k]] = 1'b0;
               end
            end
            alloc_d = alloc_q + n_acc;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NR_ENTRIES; i++)
            st_q[i] <= E_FREE;
         exc_q   <= '0;
         cmt_q   <= '0;
         iss_q   <= '0;
         alloc_q <= '0;
      end else begin
         st_q    <= st_d;
         exc_q   <= exc_d;
         cmt_q   <= cmt_d;
         iss_q   <= iss_d;
         alloc_q <= alloc_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned k = 0; k < NR_DISP_PORTS; k++)
         if (!flush_i && !flush_unissued_i && acc[k])
            pay_q[disp_idx[k]] <= disp_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
   end

endmodule

// File: tb/tb_issue_tracker_mp.sv
// Directed bench for issue_tracker_mp: vector table plus hand sequences for
// fill/gap, reset, and a 20-instruction wrap stream.
module tb_issue_tracker_mp;

   logic         clk = 1'b0;
   logic         rst, flush, flush_u, ia;
   logic [1:0]   dv, dr, cv, cx, ca;
   logic [127:0] dp, cpay;
   logic         iv, full, empty;
   logic [63:0]  ipay;
   logic [2:0]   itid;
   logic [3:0]   wbv, wbe, cnt;
   logic [11:0]  wbt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  dv;
      logic [15:0] p0, p1;
      logic        ia;
      logic [3:0]  wbv;
      logic [2:0]  t0, t1, t2, t3;
      logic [3:0]  wbe;
      logic [1:0]  ca;
      logic        fu, fl;
      logic [3:0]  cnt;
      logic        iv;
      logic [2:0]  tid;
      logic [1:0]  cv, cx;
      logic [15:0] cp0, cp1;
      logic [1:0]  dr;
   } vec_t;

   vec_t vecs [18];

   issue_tracker_mp #(
      .NR_ENTRIES(8), .NR_DISP_PORTS(2), .NR_WB_PORTS(4),
      .NR_COMMIT_PORTS(2), .PAYLOAD_W(64)
   ) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_unissued_i(flush_u),
      .disp_valid_i(dv), .disp_payload_i(dp), .disp_ready_o(dr),
      .iss_valid_o(iv), .iss_payload_o(ipay), .iss_tid_o(itid), .iss_ack_i(ia),
      .wb_valid_i(wbv), .wb_tid_i(wbt), .wb_exc_i(wbe),
      .commit_valid_o(cv), .commit_payload_o(cpay), .commit_exc_o(cx),
      .commit_ack_i(ca), .count_o(cnt), .full_o(full), .empty_o(empty)
   );

   always #5 clk = ~clk;

   // Commit acks must always form a prefix of valid slots.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!ca[0] || cv[0]) else $error("commit ack on invalid slot 0");
         assert (!ca[1] || (cv[1] && ca[0])) else $error("commit ack slot 1 not a valid prefix");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   function automatic vec_t mk(int dv_, int p0, int p1, int ia_, int wbv_, int t0, int t1,
                               int t2, int t3, int wbe_, int ca_, int fu, int fl, int cnt_,
                               int iv_, int tid, int cv_, int cx_, int cp0, int cp1, int dr_);
      vec_t v;
      v.dv = dv_[1:0];   v.p0 = p0[15:0];  v.p1 = p1[15:0];  v.ia = ia_[0];
      v.wbv = wbv_[3:0]; v.t0 = t0[2:0];   v.t1 = t1[2:0];   v.t2 = t2[2:0];
      v.t3 = t3[2:0];    v.wbe = wbe_[3:0]; v.ca = ca_[1:0]; v.fu = fu[0];
      v.fl = fl[0];      v.cnt = cnt_[3:0]; v.iv = iv_[0];   v.tid = tid[2:0];
      v.cv = cv_[1:0];   v.cx = cx_[1:0];  v.cp0 = cp0[15:0]; v.cp1 = cp1[15:0];
      v.dr = dr_[1:0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle;
      flush = 1'b0; flush_u = 1'b0; dv = '0; dp = '0; ia = 1'b0;
      wbv = '0; wbt = '0; wbe = '0; ca = '0;
   endtask

   initial begin
      //            dv p0 p1 ia wbv t0 t1 t2 t3 wbe ca fu fl | cnt iv tid cv cx cp0 cp1 dr
      vecs[0]  = mk(3, 1, 2, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  2, 1, 0, 0, 0, 0, 0, 3);
      vecs[1]  = mk(1, 3, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  3, 1, 1, 0, 0, 0, 0, 3);
      vecs[2]  = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  3, 1, 2, 0, 0, 0, 0, 3);
      vecs[3]  = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  3, 0, 3, 0, 0, 0, 0, 3);
      vecs[4]  = mk(0, 0, 0, 0, 'b0001, 2, 0, 0, 0, 0, 0, 0, 0,  3, 0, 3, 0, 0, 0, 0, 3);
      vecs[5]  = mk(0, 0, 0, 0, 'b0010, 0, 0, 0, 0, 'b0010, 0, 0, 0,  3, 0, 3, 1, 1, 1, 0, 3);
      vecs[6]  = mk('b10, 0, 99, 0, 'b1100, 0, 0, 1, 1, 'b1000, 0, 0, 0,  3, 0, 3, 3, 3, 1, 2, 3);
      vecs[7]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  3, 0, 0,  1, 0, 3, 1, 0, 3, 0, 3);
      vecs[8]  = mk(3, 4, 5, 1, 'b0001, 3, 0, 0, 0, 0, 1, 0, 0,  2, 1, 3, 0, 0, 0, 0, 3);
      vecs[9]  = mk(0, 0, 0, 1, 'b0001, 3, 0, 0, 0, 0, 0, 0, 0,  2, 1, 4, 0, 0, 0, 0, 3);
      vecs[10] = mk(3, 6, 7, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0,  1, 0, 4, 0, 0, 0, 0, 3);
      vecs[11] = mk(0, 0, 0, 0, 'b0001, 3, 0, 0, 0, 0, 0, 0, 0,  1, 0, 4, 1, 0, 4, 0, 3);
      vecs[12] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 4, 0, 0, 0, 0, 3);
      vecs[13] = mk(3, 8, 9, 1, 0,  0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 3);
      vecs[14] = mk(3, 10, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0, 3);
      vecs[15] = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 3);
      vecs[16] = mk(0, 0, 0, 0, 'b0001, 0, 0, 0, 0, 'b0001, 0, 0, 0,  1, 0, 1, 1, 1, 10, 0, 3);
      vecs[17] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 1, 0, 0, 0, 0, 3);

      rst = 1'b1;
      idle();
      step();
      rst = 1'b0;
      chk("reset.count", cnt, 0);
      chk("reset.empty", empty, 1);
      chk("reset.full", full, 0);
      chk("reset.iss_valid", iv, 0);
      chk("reset.commit_valid", cv, 0);
      chk("reset.disp_ready", dr, 2'b11);

      for (int i = 0; i < 18; i++) begin
         dv = vecs[i].dv;
         dp = {48'h0, vecs[i].p1, 48'h0, vecs[i].p0};
         ia = vecs[i].ia;
         wbv = vecs[i].wbv;
         wbt = {vecs[i].t3, vecs[i].t2, vecs[i].t1, vecs[i].t0};
         wbe = vecs[i].wbe;
         ca = vecs[i].ca;
         flush_u = vecs[i].fu;
         flush = vecs[i].fl;
         step();
         idle();
         chk($sformatf("v%0d.count", i), cnt, vecs[i].cnt);
         chk($sformatf("v%0d.full", i), full, vecs[i].cnt == 4'd8);
         chk($sformatf("v%0d.empty", i), empty, vecs[i].cnt == 4'd0);
         chk($sformatf("v%0d.iss_valid", i), iv, vecs[i].iv);
         chk($sformatf("v%0d.iss_tid", i), itid, vecs[i].tid);
         chk($sformatf("v%0d.commit_valid", i), cv, vecs[i].cv);
         chk($sformatf("v%0d.commit_exc", i), cx & vecs[i].cv, vecs[i].cx);
         chk($sformatf("v%0d.disp_ready", i), dr, vecs[i].dr);
         if (vecs[i].cv[0]) chk($sformatf("v%0d.commit_pay0", i), cpay[63:0], 64'(vecs[i].cp0));
         if (vecs[i].cv[1]) chk($sformatf("v%0d.commit_pay1", i), cpay[127:64], 64'(vecs[i].cp1));
      end

      // Fill from a non-zero pointer base so the wrap bit decides full.
      for (int i = 0; i < 4; i++) begin
         dv = 2'b11;
         step();
      end
      idle();
      chk("fill.count", cnt, 8);
      chk("fill.full", full, 1);
      chk("fill.empty", empty, 0);
      chk("fill.disp_ready", dr, 2'b00);
      chk("fill.iss_tid", itid, 1);
      dv = 2'b11;
      step();
      idle();
      chk("fill.hold_count", cnt, 8);

      flush = 1'b1;
      step();
      idle();
      chk("flush.count", cnt, 0);
      for (int i = 0; i < 3; i++) begin
         dv = 2'b11;
         step();
      end
      dv = 2'b01;
      step();
      idle();
      chk("gap.count7", cnt, 7);
      chk("gap.disp_ready", dr, 2'b01);
      dv = 2'b11;
      step();
      idle();
      chk("gap.count8", cnt, 8);
      chk("gap.full", full, 1);

      flush = 1'b1;
      step();
      idle();
      dv = 2'b11; step();
      dv = 2'b11; step();
      dv = 2'b01; step();
      idle();
      chk("pre_reset.count", cnt, 5);
      rst = 1'b1;
      dv = 2'b11;
      ia = 1'b1;
      step();
      rst = 1'b0;
      idle();
      chk("midreset.count", cnt, 0);
      chk("midreset.empty", empty, 1);
      chk("midreset.full", full, 0);
      chk("midreset.iss_valid", iv, 0);
      chk("midreset.commit_valid", cv, 0);
      chk("midreset.disp_ready", dr, 2'b11);

      for (int i = 0; i < 20; i++) begin
         dv = 2'b01;
         dp = {64'h0, 64'(32'h100 + i)};
         step();
         idle();
         chk($sformatf("wrap%0d.iss_valid", i), iv, 1);
         chk($sformatf("wrap%0d.iss_tid", i), itid, 64'(i % 8));
         chk($sformatf("wrap%0d.iss_pay", i), ipay, 64'(32'h100 + i));
         ia = 1'b1;
         step();
         idle();
         wbv = 4'b0001;
         wbt = {9'h0, 3'(i % 8)};
         step();
         idle();
         chk($sformatf("wrap%0d.commit_valid", i), cv, 2'b01);
         chk($sformatf("wrap%0d.commit_pay", i), cpay[63:0], 64'(32'h100 + i));
         ca = 2'b01;
         step();
         idle();
      end
      chk("wrap.final_count", cnt, 0);
      chk("wrap.final_empty", empty, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
